amostra_pixels: RTL

- Upstream neighbour of identifica_cores. Watches the camera pixel stream (RGB565, one pixel per valid strobe, href/vsync framing) and captures one frame.
- Captures exactly 9 sample pixels: the centres of the 3x3 sticker grid of the cube face in view.
- Stores the samples in a 3x3 buffer. identifica_cores reads the buffer through linha/coluna addresses with 1-cycle read latency, replacing the bench ROM.

---
 rtl/amostra_pixels.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/amostra_pixels.sv
// amostra_pixels: captures nine sample pixels (the 3x3 sticker centres of a
// cube face) from one camera frame into a 3x3 buffer that identifica_cores
// reads through linha/coluna addresses with one cycle of read latency.
//
// Optional build macro ESPELHO_HORIZONTAL_EN: when defined, grid column c is
// stored at buffer column 2-c to undo a horizontally mirrored camera.
//
// state          | code | meaning
// OCIOSO         |  0   | idle, waiting for iniciar
// ESPERA_QUADRO  |  1   | armed, waiting for a vsync rising edge
// CAPTURA        |  2   | counting x/y and storing samples
// FIM            |  3   | all nine samples stored, pronto pulses
// (other)        |  F   | illegal code, recovers to OCIOSO
module amostra_pixels #(
  parameter int LARGURA = 320,
  parameter int ALTURA  = 240,
  parameter int X0      = 100,
  parameter int Y0      = 60,
  parameter int PASSO   = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        vsync,
  input  logic        href,
  input  logic        pixel_valid,
  input  logic [15:0] pixel_in,
  input  logic [1:0]  linha_pixel_addr,
  input  logic [1:0]  coluna_pixel_addr,
  output logic [15:0] pixel,
  output logic        pronto,
  output logic        ocupado,
  output logic        erro_quadro,
  output logic [3:0]  db_estado
);

  localparam int XW = $clog2(LARGURA);
  localparam int YW = $clog2(ALTURA);

  localparam logic [XW-1:0] X_MAX = XW'(LARGURA - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ALTURA - 1);
  localparam logic [XW-1:0] COL0  = XW'(X0);
  localparam logic [XW-1:0] COL1  = XW'(X0 + PASSO);
  localparam logic [XW-1:0] COL2  = XW'(X0 + 2 * PASSO);
  localparam logic [YW-1:0] ROW0  = YW'(Y0);
  localparam logic [YW-1:0] ROW1  = YW'(Y0 + PASSO);
  localparam logic [YW-1:0] ROW2  = YW'(Y0 + 2 * PASSO);

  // Three state bits so that illegal codes exist and can be reported as 4'hF.
  localparam logic [2:0] OCIOSO        = 3'd0;
  localparam logic [2:0] ESPERA_QUADRO = 3'd1;
  localparam logic [2:0] CAPTURA       = 3'd2;
  localparam logic [2:0] FIM           = 3'd3;

  logic [2:0]    estado, prox_estado;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [3:0]    amostras;
  logic          vsync_q, href_q;
  logic          vsync_sobe, href_desce;
  logic          pixel_ok;
  logic          col_hit, row_hit;
  logic [1:0]    col_idx, row_idx, col_wr;
  logic          escreve, ultima;
  logic [15:0]   buffer [0:2][0:2];

  assign vsync_sobe = vsync & ~vsync_q;
  assign href_desce = href_q & ~href;
  assign pixel_ok   = pixel_valid & href;

  // Single registered copy of the framing signals for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
    end
  end

  // Decode whether the current pixel position lies on a sample column/row.
  always_comb begin
    col_hit = 1'b1;
    col_idx = 2'd0;
    row_hit = 1'b1;
    row_idx = 2'd0;
    if (x == COL0)      col_idx = 2'd0;
    else if (x == COL1) col_idx = 2'd1;
    else if (x == COL2) col_idx = 2'd2;
    else                col_hit = 1'b0;
    if (y == ROW0)      row_idx = 2'd0;
    else if (y == ROW1) row_idx = 2'd1;
    else if (y == ROW2) row_idx = 2'd2;
    else                row_hit = 1'b0;
  end

`ifdef ESPELHO_HORIZONTAL_EN
  assign col_wr = 2'd2 - col_idx;
`else
  assign col_wr = col_idx;
`endif

  assign escreve = (estado == CAPTURA) && pixel_ok && col_hit && row_hit;
  assign ultima  = escreve && (amostras == 4'd8);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox_estado;
  end

  // Next-state logic; the ninth write beats a simultaneous vsync edge.
  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:        if (iniciar)    prox_estado = ESPERA_QUADRO;
      ESPERA_QUADRO: if (vsync_sobe) prox_estado = CAPTURA;
      CAPTURA:       if (ultima)     prox_estado = FIM;
      FIM:                           prox_estado = OCIOSO;
      default:                       prox_estado = OCIOSO;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    pronto    = 1'b0;
    ocupado   = 1'b0;
    db_estado = 4'hF;
    case (estado)
      OCIOSO:        db_estado = 4'h0;
      ESPERA_QUADRO: begin db_estado = 4'h1; ocupado = 1'b1; end
      CAPTURA:       begin db_estado = 4'h2; ocupado = 1'b1; end
      FIM:           begin db_estado = 4'h3; pronto  = 1'b1; end
      default:       db_estado = 4'hF;
    endcase
  end

  // Pixel/line position and sample counter; both positions saturate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x        <= '0;
      y        <= '0;
      amostras <= 4'd0;
    end else if (estado == ESPERA_QUADRO && vsync_sobe) begin
      x        <= '0;
      y        <= '0;
      amostras <= 4'd0;
    end else if (estado == CAPTURA) begin
      if (vsync_sobe && !ultima) begin
        x        <= '0;
        y        <= '0;
        amostras <= 4'd0;
      end else begin
        if (escreve) amostras <= amostras + 4'd1;
        if (href_desce) begin
          x <= '0;
          if (y != Y_MAX) y <= y + 1'b1;
        end else if (pixel_ok && x != X_MAX) begin
          x <= x + 1'b1;
        end
      end
    end
  end

  // Sticky truncated-frame flag, cleared only when a capture is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                     erro_quadro <= 1'b0;
    else if (estado == OCIOSO && iniciar)           erro_quadro <= 1'b0;
    else if (estado == CAPTURA && vsync_sobe && !ultima) erro_quadro <= 1'b1;
  end

  // Sample buffer; partial data from an aborted frame is simply overwritten.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < 3; l++)
        for (int c = 0; c < 3; c++)
          buffer[l][c] <= 16'h0000;
    end else if (escreve) begin
      buffer[row_idx][col_wr] <= pixel_in;
    end
  end

  // Registered read port; a same-cycle write is seen on the following read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      pixel <= 16'h0000;
    else if (linha_pixel_addr == 2'd3 || coluna_pixel_addr == 2'd3)
      pixel <= 16'h0000;
    else
      pixel <= buffer[linha_pixel_addr][coluna_pixel_addr];
  end

endmodule
